param_shift_register: RTL and testbench

- Parametrised serial-to-parallel operand loader for compressor test harnesses. Supersedes the fixed 19x19 loader.
- NCH channels, each with a WIDTH-bit shift register loaded one bit per cycle. Presents a flattened parallel bus to a downstream combinational compressor and captures the compressor result back into a registered output.
- Adds a fill counter, a sliding-window mode, a capture handshake and a frame counter.

---
 rtl/param_shift_register.sv | 111 +++++++++++
 tb/tb_param_shift_register.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_shift_register.sv
// param_shift_register: NCH-channel serial-to-parallel operand loader that feeds a combinational
// compressor and captures its result. Define SHREG_PAR_LOAD_EN to add the par_load/par_in ports.
module param_shift_register #(
    parameter int NCH   = 19,
    parameter int WIDTH = 19,
    parameter int RES_W = 24,
    parameter int FRM_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [NCH-1:0]         src_in,
`ifdef SHREG_PAR_LOAD_EN
    input  logic                   par_load,
    input  logic [NCH*WIDTH-1:0]   par_in,
`endif
    output logic [NCH*WIDTH-1:0]   par_out,
    output logic                   loaded,
    input  logic [RES_W-1:0]       res_in,
    output logic [RES_W-1:0]       res_out,
    output logic                   res_valid,
    output logic [FRM_W-1:0]       frames
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [NCH*WIDTH-1:0] chan_r;
    logic [NCH*WIDTH-1:0] chan_shift_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic                 cap_pend_r;
    logic [RES_W-1:0]     res_out_r;
    logic                 res_valid_r;
    logic [FRM_W-1:0]     frames_r;
    logic                 load_s;
    logic [NCH*WIDTH-1:0] load_data_s;

`ifdef SHREG_PAR_LOAD_EN
    assign load_s      = par_load;
    assign load_data_s = par_in;
`else
    assign load_s      = 1'b0;
    assign load_data_s = '0;
`endif

    // Next channel contents: newest bit enters at the LSB of every channel.
    always_comb begin
        chan_shift_s = chan_r;
        for (int i = 0; i < NCH; i++) begin
            chan_shift_s[i*WIDTH +: WIDTH] = {chan_r[i*WIDTH +: WIDTH-1], src_in[i]};
        end
    end

    // Fill counter saturates at WIDTH so the window keeps sliding once full.
    always_comb begin
        if (cnt_r == CNT_FULL) begin
            cnt_inc_s = CNT_FULL;
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end
    end

    // Channel registers, fill counter and capture request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_r     <= '0;
            cnt_r      <= '0;
            cap_pend_r <= 1'b0;
        end else if (clear) begin
            chan_r     <= '0;
            cnt_r      <= '0;
            cap_pend_r <= 1'b0;
        end else if (load_s) begin
            chan_r     <= load_data_s;
            cnt_r      <= CNT_FULL;
            cap_pend_r <= 1'b1;
        end else if (shift_en) begin
            chan_r     <= chan_shift_s;
            cnt_r      <= cnt_inc_s;
            cap_pend_r <= (cnt_inc_s == CNT_FULL);
        end else begin
            cap_pend_r <= 1'b0;
        end
    end

    // Result capture one edge after a full window appears; clear cancels a pending capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_out_r   <= '0;
            res_valid_r <= 1'b0;
            frames_r    <= '0;
        end else if (clear) begin
            res_valid_r <= 1'b0;
        end else if (cap_pend_r) begin
            res_out_r   <= res_in;
            res_valid_r <= 1'b1;
            frames_r    <= frames_r + FRM_W'(1);
        end else begin
            res_valid_r <= 1'b0;
        end
    end

    assign par_out   = chan_r;
    assign loaded    = (cnt_r == CNT_FULL);
    assign res_out   = res_out_r;
    assign res_valid = res_valid_r;
    assign frames    = frames_r;

endmodule

// File: tb/tb_param_shift_register.sv
// Randomized self-checking bench for param_shift_register against a window/arithmetic model;
// also exercises a small NCH=2, WIDTH=4 instance. Par-load tests run when SHREG_PAR_LOAD_EN is set.
module tb_param_shift_register;

    localparam int NCH   = 19;
    localparam int WIDTH = 19;
    localparam int RES_W = 24;
    localparam int FRM_W = 16;
    localparam int PW    = NCH * WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              shift_en;
    logic [NCH-1:0]    src_in;
`ifdef SHREG_PAR_LOAD_EN
    logic              par_load;
    logic [PW-1:0]     par_in;
`endif
    logic [PW-1:0]     par_out;
    logic              loaded;
    logic [RES_W-1:0]  res_in;
    logic [RES_W-1:0]  res_out;
    logic              res_valid;
    logic [FRM_W-1:0]  frames;

    logic              s_clear;
    logic              s_shift;
    logic [1:0]        s_src;
`ifdef SHREG_PAR_LOAD_EN
    logic              s_par_load;
    logic [7:0]        s_par_in;
`endif
    logic [7:0]        s_par_out;
    logic              s_loaded;
    logic [7:0]        s_res_out;
    logic              s_res_valid;
    logic [3:0]        s_frames;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel is a number, shifted by doubling plus the new bit mod 2^WIDTH.
    int              ch_m [NCH];
    int              nshift_m;
    bit              pend_m;
    bit              valid_m;
    logic [RES_W-1:0] res_m;
    int              frames_m;

    always #5 clk = ~clk;

    // Stand-in compressor: XOR-fold of the parallel bus into RES_W bits.
    function automatic logic [RES_W-1:0] fold(input logic [PW-1:0] v);
        logic [RES_W-1:0] r;
        r = '0;
        for (int i = 0; i < PW; i++) r[i % RES_W] = r[i % RES_W] ^ v[i];
        return r;
    endfunction

    assign res_in = fold(par_out);

    param_shift_register #(.NCH(NCH), .WIDTH(WIDTH), .RES_W(RES_W), .FRM_W(FRM_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .shift_en(shift_en), .src_in(src_in),
`ifdef SHREG_PAR_LOAD_EN
        .par_load(par_load), .par_in(par_in),
`endif
        .par_out(par_out), .loaded(loaded), .res_in(res_in), .res_out(res_out),
        .res_valid(res_valid), .frames(frames)
    );

    param_shift_register #(.NCH(2), .WIDTH(4), .RES_W(8), .FRM_W(4)) dut_small (
        .clk(clk), .rst(rst), .clear(s_clear), .shift_en(s_shift), .src_in(s_src),
`ifdef SHREG_PAR_LOAD_EN
        .par_load(s_par_load), .par_in(s_par_in),
`endif
        .par_out(s_par_out), .loaded(s_loaded), .res_in(s_par_out), .res_out(s_res_out),
        .res_valid(s_res_valid), .frames(s_frames)
    );

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] exp_par();
        logic [PW-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i*WIDTH +: WIDTH] = WIDTH'(ch_m[i]);
        return v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NCH; i++) ch_m[i] = 0;
        nshift_m = 0;
        pend_m   = 1'b0;
        valid_m  = 1'b0;
        res_m    = '0;
        frames_m = 0;
    endtask

    task automatic model_edge(input bit sh, input bit cl, input logic [NCH-1:0] src,
                              input bit pl, input logic [PW-1:0] pin);
        logic [PW-1:0] cur;
        cur = exp_par();
        if (cl) begin
            for (int i = 0; i < NCH; i++) ch_m[i] = 0;
            nshift_m = 0;
            pend_m   = 1'b0;
            valid_m  = 1'b0;
        end else begin
            if (pend_m) begin
                res_m    = fold(cur);
                valid_m  = 1'b1;
                frames_m = (frames_m + 1) % (1 << FRM_W);
            end else begin
                valid_m = 1'b0;
            end
            if (pl) begin
                for (int i = 0; i < NCH; i++) ch_m[i] = int'(pin[i*WIDTH +: WIDTH]);
                nshift_m = WIDTH;
                pend_m   = 1'b1;
            end else if (sh) begin
                for (int i = 0; i < NCH; i++) ch_m[i] = (ch_m[i] * 2 + int'(src[i])) % (1 << WIDTH);
                nshift_m = nshift_m + 1;
                pend_m   = (nshift_m >= WIDTH);
            end else begin
                pend_m = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        check("par_out",   par_out,   exp_par());
        check("loaded",    loaded,    (nshift_m >= WIDTH));
        check("res_valid", res_valid, valid_m);
        check("res_out",   res_out,   res_m);
        check("frames",    frames,    FRM_W'(frames_m));
    endtask

    task automatic step(input bit sh, input bit cl, input logic [NCH-1:0] src,
                        input bit pl, input logic [PW-1:0] pin);
        @(negedge clk);
        shift_en = sh;
        clear    = cl;
        src_in   = src;
`ifdef SHREG_PAR_LOAD_EN
        par_load = pl;
        par_in   = pin;
`endif
        @(posedge clk);
        model_edge(sh, cl, src, pl, pin);
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0]    c0;
        logic [3:0]    c1;
        logic [PW-1:0] zero_v;
        logic [PW-1:0] ones_v;
        logic [RES_W-1:0] r0;
        int            f0;

        zero_v = '0;
        ones_v = '1;
        rst = 1'b1; clear = 1'b0; shift_en = 1'b0; src_in = '0;
        s_clear = 1'b0; s_shift = 1'b0; s_src = 2'b00;
`ifdef SHREG_PAR_LOAD_EN
        par_load = 1'b0; par_in = '0; s_par_load = 1'b0; s_par_in = 8'h00;
`endif
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_par_out", par_out, zero_v);
        check("rst_loaded", loaded, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_out", res_out, '0);
        check("rst_frames", frames, '0);
        @(negedge clk);
        rst = 1'b0;

        // Small instance: ch0 gets 1,0,1,1 and ch1 gets 0,0,0,1 (first bit first).
        c0 = 4'b1101;
        c1 = 4'b1000;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            s_shift = 1'b1;
            s_src   = {c1[e], c0[e]};
            @(posedge clk);
            #1;
            check("small_loaded", s_loaded, (e == 3));
        end
        check("small_ch0", s_par_out[3:0], 4'hB);
        check("small_ch1", s_par_out[7:4], 4'h1);
        @(negedge clk);
        s_shift = 1'b0;
        @(posedge clk);
        #1;
        check("small_res_valid", s_res_valid, 1'b1);
        check("small_res_out", s_res_out, 8'h1B);
        check("small_frames", s_frames, 4'd1);

        // Fill with all-ones.
        for (int k = 0; k < WIDTH; k++) step(1'b1, 1'b0, '1, 1'b0, '0);
        check("fill_ones", par_out, ones_v);
        check("fill_frames0", frames, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0);
        check("fill_res_valid", res_valid, 1'b1);
        check("fill_frames1", frames, FRM_W'(1));
        step(1'b0, 1'b0, '0, 1'b0, '0);

        // Five back-to-back sliding-window shifts, then a gapped pattern.
        f0 = frames_m;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, NCH'($urandom), 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0);
        check("burst_frames", frames, FRM_W'(f0 + 5));
        check("burst_idle", res_valid, 1'b0);
        step(1'b1, 1'b0, NCH'($urandom), 1'b0, '0);
        step(1'b1, 1'b0, NCH'($urandom), 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, NCH'($urandom), 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0);

        // Clear right after a shift cancels the capture.
        r0 = res_m;
        f0 = frames_m;
        step(1'b1, 1'b0, NCH'($urandom), 1'b0, '0);
        step(1'b0, 1'b1, '0, 1'b0, '0);
        check("cancel_valid", res_valid, 1'b0);
        check("cancel_frames", frames, FRM_W'(f0));
        check("cancel_par", par_out, zero_v);
        check("cancel_loaded", loaded, 1'b0);
        check("cancel_res_out", res_out, r0);

        // Asynchronous reset between edges after 7 shifts.
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, NCH'($urandom), 1'b0, '0);
        @(negedge clk);
        shift_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_par", par_out, zero_v);
        check("arst_loaded", loaded, 1'b0);
        check("arst_frames", frames, '0);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            step(1'b1, 1'b0, NCH'($urandom), 1'b0, '0);
            check("refill_loaded", loaded, (k == WIDTH - 1));
        end

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), NCH'($urandom), 1'b0, '0);
        end

`ifdef SHREG_PAR_LOAD_EN
        begin
            logic [PW-1:0] p55;
            logic [PW-1:0] paa;
            for (int i = 0; i < PW; i++) begin
                p55[i] = (i % 2 == 0);
                paa[i] = (i % 2 == 1);
            end
            step(1'b0, 1'b1, '0, 1'b0, '0);
            step(1'b0, 1'b0, '0, 1'b1, p55);
            check("pload_par", par_out, p55);
            check("pload_loaded", loaded, 1'b1);
            step(1'b0, 1'b0, '0, 1'b0, '0);
            check("pload_valid", res_valid, 1'b1);
            step(1'b1, 1'b0, NCH'($urandom), 1'b1, paa);
            check("pload_wins", par_out, paa);
            step(1'b0, 1'b0, '0, 1'b0, '0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
